// File: rtl/bingo_pkg.sv
// Shared types and helpers for the bingo board number-entry blocks.
package bingo_pkg;

  localparam int MAX_SIDE = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    AUTO = 2'd2,
    FIN  = 2'd3
  } sel_state_e;

  typedef struct packed {
    logic       ok;
    logic [7:0] value;
  } bcd_dec_t;

  // ok flags that both digits are decimal; value is only meaningful when ok is set
  function automatic bcd_dec_t bcd2bin(input logic [7:0] bcd);
    bcd_dec_t r;
    r.ok    = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    r.value = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/board_select_lowest_unused.sv
// Priority encoder returning the lowest number (1-based) whose used bit is clear.
module lowest_unused #(
  parameter int CELLS = 25,
  parameter int NUM_W = 5
) (
  input  logic [CELLS-1:0] used_i,
  output logic [NUM_W-1:0] value_o,
  output logic             found_o
);

  // Scan downward so the lowest free entry is the last one to win
  always_comb begin
    value_o = '0;
    found_o = 1'b0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (!used_i[i]) begin
        value_o = NUM_W'(i + 1);
        found_o = 1'b1;
      end else begin
        value_o = value_o;
      end
    end
  end

endmodule

// File: rtl/board_select.sv
// Collects a permutation of 1..SIDE^2 from BCD keypad entries into a packed board map.
module board_select
  import bingo_pkg::*;
#(
  parameter int SIDE  = 5,
  parameter int CELLS = SIDE * SIDE,
  parameter int NUM_W = $clog2(CELLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic                   start_sel,
  input  logic [7:0]             cur_number_BCD,
  input  logic                   enter_pulse,
  input  logic                   undo_pulse,
  input  logic                   auto_fill,
  output logic                   sel_done,
  output logic                   busy,
  output logic                   reject_pulse,
  output logic [NUM_W-1:0]       filled_count,
  output logic [CELLS*NUM_W-1:0] map
);

  localparam int IDX_W = $clog2(CELLS);

  sel_state_e               state_q, state_d;
  logic [CELLS*NUM_W-1:0]   map_q, map_d;
  logic [CELLS-1:0]         used_q, used_d;
  logic [NUM_W-1:0]         cnt_q, cnt_d;
  logic                     rej_q, rej_d;

  bcd_dec_t                 dec_s;
  logic                     ent_ok_s;
  logic                     full_s;
  logic [IDX_W-1:0]         ent_idx_s;
  logic [IDX_W-1:0]         wr_slot_s;
  logic [IDX_W-1:0]         undo_slot_s;
  logic [NUM_W-1:0]         undo_val_s;
  logic [IDX_W-1:0]         undo_idx_s;
  logic [NUM_W-1:0]         low_val_s;
  logic [IDX_W-1:0]         low_idx_s;
  logic                     low_found_s;

  lowest_unused #(
    .CELLS (CELLS),
    .NUM_W (NUM_W)
  ) u_lowest (
    .used_i  (used_q),
    .value_o (low_val_s),
    .found_o (low_found_s)
  );

  // The used-bit lookup is masked by the range test, so an out-of-range index is harmless
  assign dec_s       = bcd2bin(cur_number_BCD);
  assign ent_idx_s   = IDX_W'(dec_s.value - 8'd1);
  assign ent_ok_s    = dec_s.ok && (dec_s.value >= 8'd1) && (dec_s.value <= 8'(CELLS))
                       && !used_q[ent_idx_s];
  assign full_s      = (cnt_q == NUM_W'(CELLS));
  assign wr_slot_s   = IDX_W'(cnt_q);
  assign undo_slot_s = IDX_W'(cnt_q - NUM_W'(1));
  assign undo_val_s  = map_q[undo_slot_s*NUM_W +: NUM_W];
  assign undo_idx_s  = IDX_W'(undo_val_s - NUM_W'(1));
  assign low_idx_s   = IDX_W'(low_val_s - NUM_W'(1));

  // Next-state decode for the FSM, board map, used bitmap and reject strobe
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    used_d  = used_q;
    cnt_d   = cnt_q;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_sel) begin
          state_d = SEL;
          map_d   = '0;
          used_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEL: begin
        if (full_s) begin
          state_d = FIN;
        end else if (enter_pulse && undo_pulse) begin
          rej_d = 1'b1;
        end else if (enter_pulse) begin
          if (ent_ok_s) begin
            map_d[wr_slot_s*NUM_W +: NUM_W] = NUM_W'(dec_s.value);
            used_d[ent_idx_s]               = 1'b1;
            cnt_d                           = cnt_q + NUM_W'(1);
          end else begin
            rej_d = 1'b1;
          end
        end else if (undo_pulse) begin
          if (cnt_q != '0) begin
            map_d[undo_slot_s*NUM_W +: NUM_W] = '0;
            used_d[undo_idx_s]                = 1'b0;
            cnt_d                             = cnt_q - NUM_W'(1);
          end else begin
            rej_d = 1'b1;
          end
        end else if (auto_fill) begin
          state_d = AUTO;
        end else begin
          state_d = SEL;
        end
      end
      AUTO: begin
        if (full_s) begin
          state_d = FIN;
        end else if (low_found_s) begin
          map_d[wr_slot_s*NUM_W +: NUM_W] = low_val_s;
          used_d[low_idx_s]               = 1'b1;
          cnt_d                           = cnt_q + NUM_W'(1);
        end else begin
          state_d = AUTO;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; the sibling board's clear acts like reset but on the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      map_q   <= '0;
      used_q  <= '0;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
    end else if (interboard_rst) begin
      state_q <= IDLE;
      map_q   <= '0;
      used_q  <= '0;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      used_q  <= used_d;
      cnt_q   <= cnt_d;
      rej_q   <= rej_d;
    end
  end

  assign busy         = (state_q == SEL) || (state_q == AUTO);
  assign sel_done     = (state_q == FIN);
  assign reject_pulse = rej_q;
  assign filled_count = cnt_q;
  assign map          = map_q;

endmodule
